// File: rtl/npu_spi_result_tx_if.sv
// Controller-side strobe/data plus SPI pin signals of the NPU result transmitter.
// The master drives the load strobe and SPI pins; the slave is the transmitter.
interface npu_spi_result_tx_if #(
  parameter int DATA_W = 32
);
  logic              load_to_spi;
  logic [DATA_W-1:0] neuron_data;
  logic              spi_cs_n;
  logic              spi_sclk;
  logic              spi_miso;
  logic              spi_miso_oe;
  logic              transmitted;
  logic              buf_full;
  logic              overflow;
  logic              tx_busy;

  modport master (
    output load_to_spi, neuron_data, spi_cs_n, spi_sclk,
    input  spi_miso, spi_miso_oe, transmitted, buf_full, overflow, tx_busy
  );

  modport slave (
    input  load_to_spi, neuron_data, spi_cs_n, spi_sclk,
    output spi_miso, spi_miso_oe, transmitted, buf_full, overflow, tx_busy
  );
endinterface

// File: rtl/npu_spi_result_tx.sv
// SPI mode-0 result return path: one-word hold buffer, valid-header shift register,
// with SPI pins oversampled in the clk domain.
module npu_spi_result_tx #(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset_b,
  npu_spi_result_tx_if.slave  bus
);
  localparam int              CNT_W    = $clog2(DATA_W + 2);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t r_state, w_state_nxt;

  logic r_cs_s1, r_cs_s2, r_cs_h;
  logic r_sclk_s1, r_sclk_s2, r_sclk_h;
  logic w_cs_fall, w_cs_rise, w_sclk_rise, w_sclk_fall;

  logic [DATA_W-1:0] r_buf, r_restore;
  logic              r_buf_valid, r_frame_valid, r_overflow, r_transmitted;
  logic [DATA_W:0]   r_shreg;
  logic [CNT_W-1:0]  r_bit_cnt;

  logic w_start, w_end, w_complete, w_abort, w_take, w_restore, w_drop_frame;
  logic w_buf_busy, w_accept, w_drop_load, w_oe;

  always_ff @(posedge clk) begin
    if (reset_b) begin
      r_cs_s1   <= 1'b1;
      r_cs_s2   <= 1'b1;
      r_cs_h    <= 1'b1;
      r_sclk_s1 <= 1'b0;
      r_sclk_s2 <= 1'b0;
      r_sclk_h  <= 1'b0;
    end else begin
      r_cs_s1   <= bus.spi_cs_n;
      r_cs_s2   <= r_cs_s1;
      r_cs_h    <= r_cs_s2;
      r_sclk_s1 <= bus.spi_sclk;
      r_sclk_s2 <= r_sclk_s1;
      r_sclk_h  <= r_sclk_s2;
    end
  end

  assign w_cs_fall   =  r_cs_h   & ~r_cs_s2;
  assign w_cs_rise   = ~r_cs_h   &  r_cs_s2;
  assign w_sclk_rise = ~r_sclk_h &  r_sclk_s2;
  assign w_sclk_fall =  r_sclk_h & ~r_sclk_s2;

  assign w_start      = (r_state == IDLE) & w_cs_fall;
  assign w_end        = (r_state == SHIFT) & w_cs_rise;
  assign w_complete   = w_end & r_frame_valid & (r_bit_cnt == LAST_BIT);
  assign w_abort      = w_end & ~w_complete;
  assign w_take       = w_start & r_buf_valid;
  assign w_restore    = w_abort & r_frame_valid & ~r_buf_valid;
  assign w_drop_frame = w_abort & r_frame_valid &  r_buf_valid;

  // Buffer occupancy after this cycle's frame events; a same-cycle load sees the result.
  assign w_buf_busy  = (r_buf_valid & ~w_take) | w_restore;
  assign w_accept    = bus.load_to_spi & ~w_buf_busy;
  assign w_drop_load = bus.load_to_spi &  w_buf_busy;

  always_ff @(posedge clk) begin
    if (reset_b) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_cs_fall) w_state_nxt = SHIFT;
      SHIFT:   if (w_cs_rise) w_state_nxt = w_complete ? DONE : IDLE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_b) begin
      r_buf         <= '0;
      r_restore     <= '0;
      r_buf_valid   <= 1'b0;
      r_frame_valid <= 1'b0;
      r_overflow    <= 1'b0;
      r_transmitted <= 1'b0;
      r_shreg       <= '0;
      r_bit_cnt     <= '0;
    end else begin
      if (w_accept) begin
        r_buf       <= bus.neuron_data;
        r_buf_valid <= 1'b1;
      end else if (w_restore) begin
        r_buf       <= r_restore;
        r_buf_valid <= 1'b1;
      end else if (w_take) begin
        r_buf_valid <= 1'b0;
      end

      if (w_drop_load || w_drop_frame) r_overflow <= 1'b1;

      // The restore copy lets an aborted frame hand its word back to the buffer.
      if (w_start) begin
        r_shreg       <= r_buf_valid ? {1'b1, r_buf} : '0;
        r_restore     <= r_buf;
        r_frame_valid <= r_buf_valid;
        r_bit_cnt     <= '0;
      end else if (r_state == SHIFT) begin
        if (w_sclk_rise && (r_bit_cnt != LAST_BIT)) r_bit_cnt <= r_bit_cnt + CNT_W'(1);
        if (w_sclk_fall) r_shreg <= {r_shreg[DATA_W-1:0], 1'b0};
      end

      r_transmitted <= (r_state == DONE);
    end
  end

  assign w_oe            = (r_state == SHIFT);
  assign bus.spi_miso_oe = w_oe;
  assign bus.spi_miso    = r_shreg[DATA_W] & w_oe;
  assign bus.transmitted = r_transmitted;
  assign bus.buf_full    = r_buf_valid;
  assign bus.overflow    = r_overflow;
  assign bus.tx_busy     = (r_state != IDLE);
endmodule

// File: tb/tb_npu_spi_result_tx.sv
// Directed bench for npu_spi_result_tx: an event-level model of buffer/frame behaviour
// checked every cycle, plus hand-computed literal expectations per scenario.
module tb_npu_spi_result_tx;
  localparam int DATA_W     = 32;
  localparam int FRAME_BITS = DATA_W + 1;
  localparam int EV_RESET   = 0;
  localparam int EV_CSFALL  = 1;
  localparam int EV_CSRISE  = 2;
  localparam int EV_LOAD    = 3;

  logic clk = 1'b0;
  logic reset_b;
  always #5 clk = ~clk;

  npu_spi_result_tx_if #(.DATA_W(DATA_W)) bus ();

  npu_spi_result_tx #(.DATA_W(DATA_W)) dut (
    .clk     (clk),
    .reset_b (reset_b),
    .bus     (bus)
  );

  int cycle      = 0;
  int errors     = 0;
  int checks     = 0;
  int pulseCount = 0;
  bit checkEn    = 1'b0;

  always @(posedge clk) cycle <= cycle + 1;

  typedef struct {
    int                atCycle;
    int                kind;
    logic [DATA_W-1:0] word;
    int                rises;
  } ev_t;
  ev_t pending[$];

  logic              mBufValid, mOverflow, mInFrame, mFrameValid;
  logic [DATA_W-1:0] mBufWord, mFrameWord;
  int                mDoneCycle, mPulseCycle;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cycle, actual, expected);
    end
  endtask

  function automatic void modelReset();
    mBufValid   = 1'b0;
    mBufWord    = '0;
    mOverflow   = 1'b0;
    mInFrame    = 1'b0;
    mFrameValid = 1'b0;
    mFrameWord  = '0;
    mDoneCycle  = -100;
    mPulseCycle = -100;
  endfunction

  function automatic void schedule(input int at, input int kind, input logic [DATA_W-1:0] word, input int rises);
    ev_t e;
    e.atCycle = at;
    e.kind    = kind;
    e.word    = word;
    e.rises   = rises;
    pending.push_back(e);
  endfunction

  // Abstract rules: a frame grabs the buffer, completes after FRAME_BITS rises, otherwise hands the word back.
  function automatic void applyEvent(input ev_t e);
    case (e.kind)
      EV_CSFALL: begin
        mInFrame    = 1'b1;
        mFrameValid = mBufValid;
        mFrameWord  = mBufWord;
        mBufValid   = 1'b0;
      end
      EV_CSRISE: begin
        mInFrame = 1'b0;
        if (mFrameValid && e.rises >= FRAME_BITS) begin
          mDoneCycle  = cycle;
          mPulseCycle = cycle + 1;
        end else if (mFrameValid) begin
          if (mBufValid) mOverflow = 1'b1;
          else begin
            mBufValid = 1'b1;
            mBufWord  = mFrameWord;
          end
        end
      end
      EV_LOAD: begin
        if (mBufValid) mOverflow = 1'b1;
        else begin
          mBufValid = 1'b1;
          mBufWord  = e.word;
        end
      end
      default: ;
    endcase
  endfunction

  function automatic logic expBit(input int r);
    if (r == 0) return mFrameValid;
    if (r <= DATA_W) return mFrameValid & mFrameWord[DATA_W-r];
    return 1'b0;
  endfunction

  // Apply due model events (reset, then frame edges, then loads) and compare every output each cycle.
  always @(negedge clk) begin
    bit gotReset;
    gotReset = 1'b0;
    foreach (pending[i]) if (pending[i].atCycle <= cycle && pending[i].kind == EV_RESET) gotReset = 1'b1;
    if (gotReset) begin
      pending.delete();
      modelReset();
    end
    for (int pass = 0; pass < 2; pass++) begin
      int i;
      i = 0;
      while (i < pending.size()) begin
        if (pending[i].atCycle <= cycle && ((pass == 0) == (pending[i].kind != EV_LOAD))) begin
          applyEvent(pending[i]);
          pending.delete(i);
        end else i++;
      end
    end
    if (checkEn) begin
      checkOutput("cyc_buf_full", bus.buf_full, mBufValid);
      checkOutput("cyc_overflow", bus.overflow, mOverflow);
      checkOutput("cyc_miso_oe", bus.spi_miso_oe, mInFrame);
      checkOutput("cyc_tx_busy", bus.tx_busy, mInFrame || (cycle == mDoneCycle));
      checkOutput("cyc_transmitted", bus.transmitted, cycle == mPulseCycle);
      if (!mInFrame) checkOutput("cyc_miso_idle", bus.spi_miso, 1'b0);
    end
    if (bus.transmitted === 1'b1) pulseCount++;
  end

  task automatic applyStimulus(input logic [DATA_W-1:0] word);
    @(negedge clk);
    bus.load_to_spi = 1'b1;
    bus.neuron_data = word;
    schedule(cycle + 1, EV_LOAD, word, 0);
    @(negedge clk);
    bus.load_to_spi = 1'b0;
  endtask

  task automatic doReset();
    @(negedge clk);
    reset_b = 1'b1;
    schedule(cycle + 1, EV_RESET, '0, 0);
    @(negedge clk);
    reset_b = 1'b0;
  endtask

  // loadAt: -2 none, -1 lands on the cs_fall action cycle, k during rise k. resetAt: rise index or -1.
  task automatic runFrame(input int nRises, input int loadAt, input logic [DATA_W-1:0] loadVal,
                          input int resetAt, output logic hdr, output logic [DATA_W-1:0] word,
                          output logic tailZero);
    logic b;
    hdr = 1'b0;
    word = '0;
    tailZero = 1'b1;
    @(negedge clk);
    bus.spi_cs_n = 1'b0;
    schedule(cycle + 3, EV_CSFALL, '0, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (loadAt == -1 && k == 1) begin
        bus.load_to_spi = 1'b1;
        bus.neuron_data = loadVal;
        schedule(cycle + 1, EV_LOAD, loadVal, 0);
      end else bus.load_to_spi = 1'b0;
    end
    for (int r = 0; r < nRises; r++) begin
      if (r == resetAt) begin
        reset_b = 1'b1;
        bus.spi_cs_n = 1'b1;
        schedule(cycle + 1, EV_RESET, '0, 0);
        @(negedge clk);
        reset_b = 1'b0;
        repeat (4) @(negedge clk);
        return;
      end
      b = bus.spi_miso;
      checkOutput("miso_bit", b, expBit(r));
      if (r == 0) hdr = b;
      else if (r <= DATA_W) word[DATA_W-r] = b;
      else if (b !== 1'b0) tailZero = 1'b0;
      bus.spi_sclk = 1'b1;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        if (r == loadAt && k == 0) begin
          bus.load_to_spi = 1'b1;
          bus.neuron_data = loadVal;
          schedule(cycle + 1, EV_LOAD, loadVal, 0);
        end else bus.load_to_spi = 1'b0;
      end
      bus.spi_sclk = 1'b0;
      repeat (4) @(negedge clk);
    end
    bus.spi_cs_n = 1'b1;
    schedule(cycle + 3, EV_CSRISE, '0, nRises);
    repeat (7) @(negedge clk);
  endtask

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic              hdr, tail;
    logic [DATA_W-1:0] word;
    int                pc0;

    reset_b         = 1'b1;
    bus.spi_cs_n    = 1'b1;
    bus.spi_sclk    = 1'b0;
    bus.load_to_spi = 1'b0;
    bus.neuron_data = '0;
    modelReset();
    repeat (3) @(negedge clk);
    checkOutput("rst_miso", bus.spi_miso, 1'b0);
    checkOutput("rst_miso_oe", bus.spi_miso_oe, 1'b0);
    checkOutput("rst_transmitted", bus.transmitted, 1'b0);
    checkOutput("rst_buf_full", bus.buf_full, 1'b0);
    checkOutput("rst_overflow", bus.overflow, 1'b0);
    checkOutput("rst_tx_busy", bus.tx_busy, 1'b0);
    checkEn = 1'b1;
    reset_b = 1'b0;

    $display("[TB] normal frame");
    applyStimulus(32'hA5C3_0F81);
    checkOutput("t1_buf_full_loaded", bus.buf_full, 1'b1);
    pc0 = pulseCount;
    runFrame(FRAME_BITS, -2, '0, -1, hdr, word, tail);
    checkOutput("t1_header", hdr, 1'b1);
    checkOutput("t1_word", word, 32'hA5C3_0F81);
    checkOutput("t1_pulses", pulseCount - pc0, 1);
    checkOutput("t1_buf_full_after", bus.buf_full, 1'b0);

    $display("[TB] empty frame");
    pc0 = pulseCount;
    runFrame(FRAME_BITS, -2, '0, -1, hdr, word, tail);
    checkOutput("t2_header", hdr, 1'b0);
    checkOutput("t2_word", word, 32'h0);
    checkOutput("t2_pulses", pulseCount - pc0, 0);
    checkOutput("t2_overflow", bus.overflow, 1'b0);

    $display("[TB] overflow");
    applyStimulus(32'h1111_1111);
    applyStimulus(32'h2222_2222);
    checkOutput("t3_overflow", bus.overflow, 1'b1);
    runFrame(FRAME_BITS, -2, '0, -1, hdr, word, tail);
    checkOutput("t3_header1", hdr, 1'b1);
    checkOutput("t3_word1", word, 32'h1111_1111);
    runFrame(FRAME_BITS, -2, '0, -1, hdr, word, tail);
    checkOutput("t3_header2", hdr, 1'b0);

    $display("[TB] abort and restore");
    applyStimulus(32'hDEAD_BEEF);
    pc0 = pulseCount;
    runFrame(10, -2, '0, -1, hdr, word, tail);
    checkOutput("t4_abort_pulses", pulseCount - pc0, 0);
    checkOutput("t4_buf_full", bus.buf_full, 1'b1);
    pc0 = pulseCount;
    runFrame(FRAME_BITS, -2, '0, -1, hdr, word, tail);
    checkOutput("t4_header", hdr, 1'b1);
    checkOutput("t4_word", word, 32'hDEAD_BEEF);
    checkOutput("t4_pulses", pulseCount - pc0, 1);

    $display("[TB] abort with buffer refilled");
    doReset();
    checkOutput("t5_overflow_cleared", bus.overflow, 1'b0);
    applyStimulus(32'hDEAD_BEEF);
    runFrame(10, 5, 32'h0000_0042, -1, hdr, word, tail);
    checkOutput("t5_overflow", bus.overflow, 1'b1);
    runFrame(FRAME_BITS, -2, '0, -1, hdr, word, tail);
    checkOutput("t5_header", hdr, 1'b1);
    checkOutput("t5_word", word, 32'h0000_0042);

    $display("[TB] reset mid-frame");
    applyStimulus(32'hCAFE_0001);
    pc0 = pulseCount;
    runFrame(FRAME_BITS, -2, '0, 16, hdr, word, tail);
    checkOutput("t6_miso", bus.spi_miso, 1'b0);
    checkOutput("t6_miso_oe", bus.spi_miso_oe, 1'b0);
    checkOutput("t6_buf_full", bus.buf_full, 1'b0);
    checkOutput("t6_overflow", bus.overflow, 1'b0);
    checkOutput("t6_tx_busy", bus.tx_busy, 1'b0);
    runFrame(FRAME_BITS, -2, '0, -1, hdr, word, tail);
    checkOutput("t6_next_header", hdr, 1'b0);
    checkOutput("t6_pulses", pulseCount - pc0, 0);

    $display("[TB] load on cs_fall cycle, extra SCLK edges");
    applyStimulus(32'h0BAD_F00D);
    runFrame(FRAME_BITS, -1, 32'h1234_5678, -1, hdr, word, tail);
    checkOutput("t7_word1", word, 32'h0BAD_F00D);
    checkOutput("t7_buf_full", bus.buf_full, 1'b1);
    checkOutput("t7_overflow", bus.overflow, 1'b0);
    pc0 = pulseCount;
    runFrame(FRAME_BITS + 3, -2, '0, -1, hdr, word, tail);
    checkOutput("t7_header2", hdr, 1'b1);
    checkOutput("t7_word2", word, 32'h1234_5678);
    checkOutput("t7_tail_zero", tail, 1'b1);
    checkOutput("t7_pulses", pulseCount - pc0, 1);

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
